// File: rtl/mat_stream_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mat_pkg
// Description : Shared types and constants for the 3x3 matrix calculator
//               slice. Holds the element/bus geometry, the stream FSM state
//               encoding and the slot(i,j) index helper used by every block
//               that packs or unpacks a flat matrix bus.
// Revision    : 1.0 - initial release
// ============================================================================
package mat_pkg;

  // Matrix geometry: N elements of ELEM_W bits, packed exactly into MAT_W.
  localparam int ELEM_W    = 16;
  localparam int DIM       = 3;
  localparam int N         = DIM * DIM;
  localparam int MAT_W     = N * ELEM_W;

  // Counter widths: input index spans both operands, output index one matrix.
  localparam int IN_CNT_W  = $clog2(2 * N);
  localparam int OUT_CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    GO    = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Flat slot number of element (i,j); slot s lives at bus[s*ELEM_W +: ELEM_W].
  function automatic int slot(input int i, input int j);
    return i * DIM + j;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mat_stream_io_if.sv
`default_nettype none
// ============================================================================
// Module      : mat_stream_io_if
// Description : Bundle of the host element streams and the Calculator bus
//               around mat_stream_io.
//   in_valid/in_data/in_ready    : host operand stream (A then B, row-major)
//   A/B/calc_go                  : packed operands and start pulse
//   done/Result                  : Calculator completion and product
//   out_valid/out_data/out_ready : result stream back to the host
//   busy/err                     : status
//   modport slave  : the mat_stream_io side
//   modport master : the host + Calculator side
// Revision    : 1.0 - initial release
// ============================================================================
interface mat_stream_io_if;
  import mat_pkg::*;

  logic              in_valid;
  logic [ELEM_W-1:0] in_data;
  logic              in_ready;
  logic [MAT_W-1:0]  A;
  logic [MAT_W-1:0]  B;
  logic              calc_go;
  logic              done;
  logic [MAT_W-1:0]  Result;
  logic              out_valid;
  logic [ELEM_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              err;

  modport slave (
    input  in_valid, in_data, done, Result, out_ready,
    output in_ready, A, B, calc_go, out_valid, out_data, busy, err
  );

  modport master (
    output in_valid, in_data, done, Result, out_ready,
    input  in_ready, A, B, calc_go, out_valid, out_data, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/mat_stream_io_slot_mux.sv
`default_nettype none
// ============================================================================
// Module      : mat_slot_mux
// Description : N-way read mux selecting one ELEM_W slot of a flat matrix bus.
//   mat  : in  N*ELEM_W  packed matrix
//   idx  : in  IDX_W     slot index (out-of-range indices read as zero)
//   elem : out ELEM_W    selected element
// Revision    : 1.0 - initial release
// ============================================================================
module mat_slot_mux #(
  parameter int ELEM_W = mat_pkg::ELEM_W,
  parameter int N      = mat_pkg::N,
  parameter int IDX_W  = $clog2(N)
) (
  input  wire logic [N*ELEM_W-1:0] mat,
  input  wire logic [IDX_W-1:0]    idx,
  output logic      [ELEM_W-1:0]   elem
);

  logic [ELEM_W-1:0] w_slots [N];

  for (genvar g = 0; g < N; g++) begin : g_slots
    assign w_slots[g] = mat[g*ELEM_W +: ELEM_W];
  end

  always_comb begin
    elem = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) elem = w_slots[k];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mat_stream_io.sv
`default_nettype none
// ============================================================================
// Module      : mat_stream_io
// Description : Streaming front/back end for the 3x3 matrix Calculator.
//               Packs 2N host elements into A/B, pulses calc_go, waits for
//               done (bounded by TIMEOUT), captures Result and streams its N
//               elements back out in row-major order.
//   Clock : in  rising-edge clock
//   reset : in  asynchronous active-high reset
//   bus   : mat_stream_io_if.slave (host streams, Calculator bus, status)
// Revision    : 1.0 - initial release
// ============================================================================
module mat_stream_io
  import mat_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input wire logic       Clock,
  input wire logic       reset,
  mat_stream_io_if.slave bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t                r_state;
  state_t                w_next;
  logic [IN_CNT_W-1:0]   r_in_cnt;
  logic [OUT_CNT_W-1:0]  r_out_cnt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [MAT_W-1:0]      r_a;
  logic [MAT_W-1:0]      r_b;
  logic [MAT_W-1:0]      r_result;
  logic                  r_err;
  logic                  w_in_ready;
  logic                  w_calc_go;
  logic                  w_out_valid;
  logic                  w_busy;
  logic [ELEM_W-1:0]     w_out_data;
  logic                  w_last_in;
  logic                  w_last_out;
  logic                  w_timeout;

  assign w_last_in  = (r_in_cnt == IN_CNT_W'(2*N - 1));
  assign w_last_out = (r_out_cnt == OUT_CNT_W'(N - 1));
  // The edge that would bring the counter to TIMEOUT is the abort edge.
  assign w_timeout  = (r_wait_cnt == WAIT_W'(TIMEOUT - 1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // Next state and handshake outputs. Ready/valid depend on state only, so
  // there is no combinational path from in_valid or out_ready.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_calc_go   = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      LOAD: begin
        w_in_ready = !reset;
        w_busy     = 1'b0;
        if (bus.in_valid && w_last_in) w_next = GO;
      end
      GO: begin
        w_calc_go = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        if (bus.done)      w_next = DRAIN;
        else if (w_timeout) w_next = LOAD;
      end
      DRAIN: begin
        w_out_valid = 1'b1;
        if (bus.out_ready && w_last_out) w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand packing, wait counter, result capture, drain index.
  // Transfers are qualified by state, which is exactly when ready/valid is up.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_wait_cnt <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (bus.in_valid) begin
            for (int k = 0; k < N; k++) begin
              if (r_in_cnt == IN_CNT_W'(k))     r_a[k*ELEM_W +: ELEM_W] <= bus.in_data;
              if (r_in_cnt == IN_CNT_W'(k + N)) r_b[k*ELEM_W +: ELEM_W] <= bus.in_data;
            end
            r_in_cnt <= w_last_in ? '0 : r_in_cnt + 1'b1;
          end
        end
        GO: r_wait_cnt <= '0;
        WAIT: begin
          if (bus.done) begin
            r_result <= bus.Result;
          end else if (w_timeout) begin
            // Abandoned job: drop the operands so a stale pair is never reused.
            r_err <= 1'b1;
            r_a   <= '0;
            r_b   <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.out_ready) r_out_cnt <= w_last_out ? '0 : r_out_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  mat_slot_mux #(
    .ELEM_W (ELEM_W),
    .N      (N),
    .IDX_W  (OUT_CNT_W)
  ) u_slot_mux (
    .mat  (r_result),
    .idx  (r_out_cnt),
    .elem (w_out_data)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.A         = r_a;
  assign bus.B         = r_b;
  assign bus.calc_go   = w_calc_go;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.busy      = w_busy;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mat_stream_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_mat_stream_io
// Description : Directed self-checking bench for mat_stream_io, with a small
//               Calculator model that multiplies the A/B buses after a
//               programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_stream_io;
  import mat_pkg::*;

  localparam int TIMEOUT = 255;
  typedef logic [ELEM_W-1:0] elem_t;

  logic Clock = 1'b0;
  logic reset;
  always #5 Clock = ~Clock;

  mat_stream_io_if bus();

  mat_stream_io #(.TIMEOUT(TIMEOUT)) dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  elem_t job_basic [2*N];
  elem_t exp_basic [N];
  elem_t job_two   [2*N];
  elem_t exp_two   [N];

  // ---------------- Calculator model ----------------
  bit calc_en   = 1'b1;
  int calc_lat  = 3;
  int spur_req  = 0;
  int spur_done = 0;
  int go_pulses = 0;

  function automatic logic [MAT_W-1:0] calc(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    logic [MAT_W-1:0]  r;
    logic [ELEM_W-1:0] acc;
    r = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        acc = '0;
        for (int k = 0; k < DIM; k++)
          acc = acc + ELEM_W'(a[slot(i,k)*ELEM_W +: ELEM_W] * b[slot(k,j)*ELEM_W +: ELEM_W]);
        r[slot(i,j)*ELEM_W +: ELEM_W] = acc;
      end
    return r;
  endfunction

  initial begin
    bus.done   = 1'b0;
    bus.Result = '0;
    forever begin
      @(negedge Clock);
      if (spur_req > spur_done) begin
        bus.Result = {MAT_W{1'b1}};
        bus.done   = 1'b1;
        @(negedge Clock);
        bus.done   = 1'b0;
        spur_done++;
      end else if (calc_en && bus.calc_go) begin
        repeat (calc_lat) @(negedge Clock);
        bus.Result = calc(bus.A, bus.B);
        bus.done   = 1'b1;
        @(negedge Clock);
        bus.done   = 1'b0;
      end
    end
  end

  always @(negedge Clock) if (bus.calc_go) go_pulses++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- Stimulus helpers (no checking) ----------------
  task automatic load_job(input elem_t elems[2*N], input bit gaps, output bit ok);
    int idx = 0;
    int cyc = 0;
    while (idx < 2*N && cyc < 600) begin
      @(negedge Clock);
      cyc++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = elems[idx];
        if (bus.in_ready) idx++;
      end
    end
    @(negedge Clock);
    bus.in_valid = 1'b0;
    ok = (idx == 2*N);
  endtask

  task automatic collect(output elem_t got[N], output int n);
    int cyc = 0;
    n = 0;
    for (int k = 0; k < N; k++) got[k] = '0;
    while (n < N && cyc < 600) begin
      @(negedge Clock);
      cyc++;
      bus.out_ready = 1'b1;
      if (bus.out_valid) begin
        got[n] = bus.out_data;
        n++;
      end
    end
    @(negedge Clock);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset;
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge Clock);
    n_checks++; if (bus.in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.err !== 1'b0)       begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.calc_go !== 1'b0)   begin n_fail++; $display("FAIL reset_calc_go: got %b want 0", bus.calc_go); end
    n_checks++; if (bus.out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
    n_checks++; if (bus.A !== '0 || bus.B !== '0) begin n_fail++; $display("FAIL reset_ab: got A=%h B=%h want 0", bus.A, bus.B); end
    reset = 1'b0;
    @(negedge Clock);
    n_checks++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic;
    bit ok;
    int n;
    int g0;
    elem_t got[N];
    logic [MAT_W-1:0] ea, eb;
    for (int s = 0; s < N; s++) begin
      ea[s*ELEM_W +: ELEM_W] = job_basic[s];
      eb[s*ELEM_W +: ELEM_W] = job_basic[s+N];
    end
    g0 = go_pulses;
    calc_lat = 3;
    load_job(job_basic, 1'b0, ok);
    n_checks++; if (!ok)                  begin n_fail++; $display("FAIL basic_load: in_ready never accepted all %0d elements", 2*N); end
    n_checks++; if (bus.calc_go !== 1'b1) begin n_fail++; $display("FAIL basic_go_latency: got calc_go=%b want 1", bus.calc_go); end
    n_checks++; if (bus.A !== ea)         begin n_fail++; $display("FAIL basic_pack_a: got %h want %h", bus.A, ea); end
    n_checks++; if (bus.B !== eb)         begin n_fail++; $display("FAIL basic_pack_b: got %h want %h", bus.B, eb); end
    collect(got, n);
    n_checks++; if (n != N)               begin n_fail++; $display("FAIL basic_count: got %0d elements want %0d", n, N); end
    for (int m = 0; m < N; m++) begin
      n_checks++; if (got[m] !== exp_basic[m]) begin n_fail++; $display("FAIL basic_out[%0d]: got %0d want %0d", m, got[m], exp_basic[m]); end
    end
    n_checks++; if (go_pulses - g0 != 1)  begin n_fail++; $display("FAIL basic_go_once: got %0d pulses want 1", go_pulses - g0); end
    n_checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int n = 0;
    int stall = 0;
    int cyc = 0;
    calc_lat = 3;
    load_job(job_basic, 1'b1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_load: load with gaps did not complete"); end
    while (n < N && cyc < 600) begin
      @(negedge Clock);
      cyc++;
      if (bus.out_valid && n == 4 && stall < 3) begin
        bus.out_ready = 1'b0;
        stall++;
        n_checks++; if (bus.out_data !== exp_basic[4]) begin n_fail++; $display("FAIL bp_hold[%0d]: got %0d want %0d", stall, bus.out_data, exp_basic[4]); end
      end else begin
        bus.out_ready = 1'b1;
        if (bus.out_valid) begin
          n_checks++; if (bus.out_data !== exp_basic[n]) begin n_fail++; $display("FAIL bp_out[%0d]: got %0d want %0d", n, bus.out_data, exp_basic[n]); end
          n++;
        end
      end
    end
    @(negedge Clock);
    bus.out_ready = 1'b0;
    n_checks++; if (n != N || stall != 3) begin n_fail++; $display("FAIL bp_count: got %0d elements %0d stalls want %0d and 3", n, stall, N); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got in_ready=%b want 1", bus.in_ready); end
  endtask

  task automatic test_timeout;
    bit ok;
    bit ov_seen = 1'b0;
    bit err_early = 1'b0;
    int n;
    elem_t got[N];
    calc_en = 1'b0;
    load_job(job_basic, 1'b0, ok);
    n_checks++; if (!ok || bus.calc_go !== 1'b1) begin n_fail++; $display("FAIL to_go: got ok=%b calc_go=%b want 1/1", ok, bus.calc_go); end
    repeat (TIMEOUT) begin
      @(negedge Clock);
      if (bus.out_valid) ov_seen = 1'b1;
      if (bus.err)       err_early = 1'b1;
    end
    n_checks++; if (err_early)  begin n_fail++; $display("FAIL to_err_early: got err=1 before %0d cycles want 0", TIMEOUT); end
    @(negedge Clock);
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b want 1", bus.err); end
    n_checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL to_load: got in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy); end
    n_checks++; if (ov_seen)    begin n_fail++; $display("FAIL to_out_valid: got out_valid=1 during wait want 0"); end
    calc_en = 1'b1;
    load_job(job_basic, 1'b0, ok);
    collect(got, n);
    n_checks++; if (n != N)     begin n_fail++; $display("FAIL to_recover_count: got %0d want %0d", n, N); end
    for (int m = 0; m < N; m++) begin
      n_checks++; if (got[m] !== exp_basic[m]) begin n_fail++; $display("FAIL to_recover_out[%0d]: got %0d want %0d", m, got[m], exp_basic[m]); end
    end
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", bus.err); end
  endtask

  task automatic test_early_done;
    bit ok;
    int n;
    elem_t got[N];
    spur_req++;
    repeat (3) @(negedge Clock);
    n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL ed_spurious: got busy=%b out_valid=%b in_ready=%b want 0/0/1", bus.busy, bus.out_valid, bus.in_ready); end
    calc_lat = 1;
    load_job(job_basic, 1'b0, ok);
    n_checks++; if (!ok || bus.calc_go !== 1'b1) begin n_fail++; $display("FAIL ed_go: got ok=%b calc_go=%b want 1/1", ok, bus.calc_go); end
    @(negedge Clock);
    n_checks++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ed_wait1: got done=%b out_valid=%b want 1/0", bus.done, bus.out_valid); end
    @(negedge Clock);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_basic[0]) begin n_fail++; $display("FAIL ed_drain: got out_valid=%b data=%0d want 1/%0d", bus.out_valid, bus.out_data, exp_basic[0]); end
    collect(got, n);
    for (int m = 0; m < N; m++) begin
      n_checks++; if (got[m] !== exp_basic[m]) begin n_fail++; $display("FAIL ed_out[%0d]: got %0d want %0d", m, got[m], exp_basic[m]); end
    end
    calc_lat = 3;
  endtask

  task automatic test_reset_mid_drain;
    bit ok;
    int n = 0;
    int cyc = 0;
    elem_t got[N];
    load_job(job_basic, 1'b0, ok);
    while (n < 5 && cyc < 600) begin
      @(negedge Clock);
      cyc++;
      bus.out_ready = 1'b1;
      if (bus.out_valid) n++;
    end
    @(negedge Clock);
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_basic[5]) begin n_fail++; $display("FAIL rm_m5: got out_valid=%b data=%0d want 1/%0d", bus.out_valid, bus.out_data, exp_basic[5]); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin n_fail++; $display("FAIL rm_out: got out_valid=%b data=%0d want 0/0", bus.out_valid, bus.out_data); end
    n_checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rm_status: got busy=%b in_ready=%b err=%b want 0/0/0", bus.busy, bus.in_ready, bus.err); end
    n_checks++; if (bus.A !== '0 || bus.B !== '0) begin n_fail++; $display("FAIL rm_ab: got A=%h B=%h want 0", bus.A, bus.B); end
    @(negedge Clock);
    reset = 1'b0;
    load_job(job_basic, 1'b0, ok);
    collect(got, n);
    n_checks++; if (n != N) begin n_fail++; $display("FAIL rm_count: got %0d want %0d", n, N); end
    for (int m = 0; m < N; m++) begin
      n_checks++; if (got[m] !== exp_basic[m]) begin n_fail++; $display("FAIL rm_out[%0d]: got %0d want %0d", m, got[m], exp_basic[m]); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2;
    int n1, n2;
    elem_t got1[N];
    elem_t got2[N];
    fork
      begin
        load_job(job_basic, 1'b0, ok1);
        load_job(job_two, 1'b0, ok2);
      end
      begin
        collect(got1, n1);
        collect(got2, n2);
      end
    join
    n_checks++; if (!ok1 || !ok2 || n1 != N || n2 != N) begin n_fail++; $display("FAIL b2b_counts: got ok=%b%b n=%0d,%0d want 11 and %0d,%0d", ok1, ok2, n1, n2, N, N); end
    for (int m = 0; m < N; m++) begin
      n_checks++; if (got1[m] !== exp_basic[m]) begin n_fail++; $display("FAIL b2b_job1[%0d]: got %0d want %0d", m, got1[m], exp_basic[m]); end
      n_checks++; if (got2[m] !== exp_two[m])   begin n_fail++; $display("FAIL b2b_job2[%0d]: got %0d want %0d", m, got2[m], exp_two[m]); end
    end
  endtask

  initial begin
    job_basic = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9,
                  16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd1};
    exp_basic = '{16'd36, 16'd42, 16'd21, 16'd81, 16'd96, 16'd57, 16'd126, 16'd150, 16'd93};
    // Second job: A = 9..1, B = 2*I, so the product is 2*A.
    job_two   = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1,
                  16'd2, 16'd0, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0, 16'd0, 16'd2};
    exp_two   = '{16'd18, 16'd16, 16'd14, 16'd12, 16'd10, 16'd8, 16'd6, 16'd4, 16'd2};

    test_reset;
    test_basic;
    test_backpressure;
    test_timeout;
    test_early_done;
    test_reset_mid_drain;
    test_back_to_back;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
